spi_pixel_rx: RTL

- Receive side of the 6-lane parallel SPI pixel link; sits directly downstream of the peripheral FPGA's spi_send_con on the main FPGA.
- Samples dclk, cs and the cipo lanes off the pins and deserializes each chip-select frame into 6 16-bit pixels.
- Emits the pixels one at a time in arrival order over a valid/ready stream, with raster hcount/vcount for the 640x360 downsampled image.
- Recovers frame alignment from link idle time.

---
 rtl/spi_pixel_rx.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_pixel_rx.sv
// Receive side of the 6-lane parallel SPI pixel link: deserializes each chip-select
// frame into LINES pixels and streams them out in arrival order with raster position.
module spi_pixel_rx #(
   parameter int LINES       = 6,
   parameter int DATA_WIDTH  = 16,
   parameter int HRES        = 640,
   parameter int VRES        = 360,
   parameter int IDLE_RESYNC = 4096
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    dclk_in,
   input  logic                    cs_in,
   input  logic [LINES-1:0]        cipo_in,
   input  logic                    ready_in,
   output logic                    pixel_valid_out,
   output logic [DATA_WIDTH-1:0]   pixel_data_out,
   output logic [$clog2(HRES)-1:0] hcount_out,
   output logic [$clog2(VRES)-1:0] vcount_out,
   output logic                    overflow_out,
   output logic [7:0]              bad_frame_count_out
);
   localparam int CW  = $clog2(DATA_WIDTH + 1);
   localparam int IW  = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int HW  = $clog2(HRES);
   localparam int VW  = $clog2(VRES);
   localparam int DW  = $clog2(IDLE_RESYNC);
   localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
   localparam logic [IW-1:0] IDX_LAST = IW'(LINES - 1);
   localparam logic [HW-1:0] H_LAST   = HW'(HRES - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(VRES - 1);
   localparam logic [DW-1:0] IDLE_MAX = DW'(IDLE_RESYNC - 1);

   typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;
   typedef enum logic {EM_EMPTY, EM_DRAIN} em_state_t;

   logic             r_dclk_meta, r_dclk_sync, r_dclk_hist;
   logic             r_cs_meta, r_cs_sync, r_cs_hist;
   logic [LINES-1:0] r_cipo_meta, r_cipo_sync;

   rx_state_t        r_rx_state, w_rx_next;
   em_state_t        r_em_state, w_em_next;

   logic [DATA_WIDTH-1:0] r_sr  [LINES];
   logic [DATA_WIDTH-1:0] r_buf [LINES];
   logic [CW-1:0]    r_bit_cnt, w_cnt_after;
   logic             r_bad, w_bad_now;
   logic             r_load_req;
   logic [IW-1:0]    r_idx;
   logic [HW-1:0]    r_hcount;
   logic [VW-1:0]    r_vcount;
   logic [DW-1:0]    r_idle_cnt;
   logic             r_resync_pending;
   logic             r_overflow;
   logic [7:0]       r_bad_cnt;

   logic w_rise, w_cs_rise, w_in_shift, w_cnt_full, w_shift_en;
   logic w_frame_end, w_frame_good;
   logic w_accept, w_last_accept, w_can_load, w_load;

   // cs synchronizer resets to the idle (high) level so reset release never looks like a frame
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_dclk_meta <= 1'b0;
         r_dclk_sync <= 1'b0;
         r_dclk_hist <= 1'b0;
         r_cs_meta   <= 1'b1;
         r_cs_sync   <= 1'b1;
         r_cs_hist   <= 1'b1;
         r_cipo_meta <= '0;
         r_cipo_sync <= '0;
      end else begin
         r_dclk_meta <= dclk_in;
         r_dclk_sync <= r_dclk_meta;
         r_dclk_hist <= r_dclk_sync;
         r_cs_meta   <= cs_in;
         r_cs_sync   <= r_cs_meta;
         r_cs_hist   <= r_cs_sync;
         r_cipo_meta <= cipo_in;
         r_cipo_sync <= r_cipo_meta;
      end
   end

   assign w_rise      = r_dclk_sync & ~r_dclk_hist;
   assign w_cs_rise   = r_cs_sync & ~r_cs_hist;
   assign w_in_shift  = (r_rx_state == RX_SHIFT);
   assign w_cnt_full  = (r_bit_cnt == CNT_FULL);
   assign w_shift_en  = w_in_shift & w_rise & ~w_cnt_full;
   assign w_cnt_after = w_shift_en ? r_bit_cnt + 1'b1 : r_bit_cnt;
   assign w_bad_now   = r_bad | (w_in_shift & w_rise & w_cnt_full);
   assign w_frame_end = w_in_shift & w_cs_rise;
   // Judged on post-shift values so a coincident last edge still counts
   assign w_frame_good = w_frame_end & ~w_bad_now & (w_cnt_after == CNT_FULL);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) r_rx_state <= RX_IDLE;
      else         r_rx_state <= w_rx_next;
   end

   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         RX_IDLE:  if (!r_cs_sync) w_rx_next = RX_SHIFT;
         RX_SHIFT: if (w_cs_rise)  w_rx_next = RX_IDLE;
         default:  w_rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_bit_cnt  <= '0;
         r_bad      <= 1'b0;
         r_load_req <= 1'b0;
         r_bad_cnt  <= '0;
         for (int i = 0; i < LINES; i++) r_sr[i] <= '0;
      end else begin
         if (r_rx_state == RX_IDLE && !r_cs_sync) begin
            r_bit_cnt <= '0;
            r_bad     <= 1'b0;
         end else if (w_in_shift) begin
            r_bit_cnt <= w_cnt_after;
            r_bad     <= w_bad_now;
         end
         if (w_shift_en) begin
            for (int i = 0; i < LINES; i++)
               r_sr[i] <= {r_sr[i][DATA_WIDTH-2:0], r_cipo_sync[i]};
         end
         r_load_req <= w_frame_good;
         if (w_frame_end && !w_frame_good && r_bad_cnt != 8'hFF)
            r_bad_cnt <= r_bad_cnt + 8'd1;
      end
   end

   assign w_accept      = (r_em_state == EM_DRAIN) & ready_in;
   assign w_last_accept = w_accept & (r_idx == '0);
   // The buffer can be refilled in the same cycle its last pixel leaves
   assign w_can_load    = (r_em_state == EM_EMPTY) | w_last_accept;
   assign w_load        = r_load_req & w_can_load;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) r_em_state <= EM_EMPTY;
      else         r_em_state <= w_em_next;
   end

   always_comb begin
      w_em_next = r_em_state;
      case (r_em_state)
         EM_EMPTY: if (w_load) w_em_next = EM_DRAIN;
         EM_DRAIN: if (w_last_accept && !w_load) w_em_next = EM_EMPTY;
         default:  w_em_next = EM_EMPTY;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_idx      <= '0;
         r_overflow <= 1'b0;
         for (int i = 0; i < LINES; i++) r_buf[i] <= '0;
      end else begin
         if (w_load) begin
            r_idx <= IDX_LAST;
            for (int i = 0; i < LINES; i++) r_buf[i] <= r_sr[i];
         end else if (w_accept) begin
            r_idx <= r_idx - 1'b1;
         end
         if (r_load_req && !w_can_load) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_idle_cnt       <= '0;
         r_resync_pending <= 1'b1;
      end else begin
         if (!r_cs_sync)
            r_idle_cnt <= '0;
         else if (r_rx_state == RX_IDLE && r_idle_cnt != IDLE_MAX)
            r_idle_cnt <= r_idle_cnt + 1'b1;
         if (w_load)
            r_resync_pending <= 1'b0;
         else if (r_idle_cnt == IDLE_MAX)
            r_resync_pending <= 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_hcount <= '0;
         r_vcount <= '0;
      end else if (w_accept) begin
         if (r_resync_pending && w_last_accept) begin
            r_hcount <= '0;
            r_vcount <= '0;
         end else if (r_hcount == H_LAST) begin
            r_hcount <= '0;
            r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
         end else begin
            r_hcount <= r_hcount + 1'b1;
         end
      end else if (r_resync_pending && r_em_state == EM_EMPTY) begin
         r_hcount <= '0;
         r_vcount <= '0;
      end
   end

   always_comb begin
      pixel_data_out = '0;
      for (int i = 0; i < LINES; i++)
         if (r_idx == IW'(i)) pixel_data_out = r_buf[i];
   end

   assign pixel_valid_out     = (r_em_state == EM_DRAIN);
   assign hcount_out          = r_hcount;
   assign vcount_out          = r_vcount;
   assign overflow_out        = r_overflow;
   assign bad_frame_count_out = r_bad_cnt;
endmodule
